osd_tep_sched: RTL and testbench
================================

// Module: osd_tep_sched
// PURPOSE
// - Test-error-pattern (TEP) scheduler for the OSD decoder. Sits after the reorder/hard-decision
//   stage and ahead of the re-encoder.
// - On start, captures the K most-reliable hard-decision bits and their reordered LLRs.
// - Emits one candidate information word per handshake: order-0 first, then every order-1 flip,
//   optionally followed by order-2 flips.
// - Each candidate carries the reliability cost of its flipped bits.
// PARAMETERS
// - K          4  number of MRB information bits per candidate
// - BIT_WIDTH  6  signed LLR width of each reordered value
// - IDX_W      $clog2(K*K+1)  candidate index width; covers order-2 count
// - CW         BIT_WIDTH+1  cost width; sum of two magnitudes
// PORTS
// - clk        in   1            rising-edge clock
// - rst        in   1            synchronous, active-high reset
// - start      in   1            begin a new codeword; sampled only in IDLE
// - a1k_in     in   K            MRB hard decisions, bit j = sign of reordered LLR j
// - v1k_in     in   K*BIT_WIDTH  first K reordered LLRs, signed, LSB-first packing
// - cand_ready in   1            downstream accepts candidate
// - cand_valid out  1            candidate outputs valid
// - cand_u     out  K            a1k XOR flip mask
// - cand_mask  out  K            flip mask of this TEP
// - cand_cost  out  CW           sum of |LLR| over flipped bits, unsigned
// - cand_idx   out  IDX_W        ordinal of candidate, 0-based
// - cand_last  out  1            final candidate of this codeword
// - busy       out  1            high from accepted start until done
// - done       out  1            one-cycle pulse after last candidate handshake
// BEHAVIOUR
// - Reset: all outputs 0; state IDLE; capture registers 0.
// - Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
// - FSM states: IDLE, ORD0, ORD1, ORD2, FIN.
//   - IDLE: start=1 latches a1k_in and v1k_in, sets busy, goes to ORD0.
//     - Latency: cand_valid is high on the cycle after start is sampled.
//   - ORD0: mask=0, cost=0, idx=0. On handshake go to ORD1 with i=0.
//   - ORD1: mask=1<<i, cost=|v[i]|. idx=1+i.
//     - On handshake with i<K-1: i++.
//     - On handshake with i=K-1: go to ORD2 with (i,j)=(0,1) if the order-2 option is on,
//       else go to FIN.
//   - ORD2: mask=(1<<i)|(1<<j), cost=|v[i]|+|v[j]|. idx increments by 1 per pattern.
//     - Pattern order is lexicographic: j++ until K-1, then i++, j=i+1.
//     - Pattern (K-2,K-1) is last; on its handshake go to FIN.
//   - FIN: done=1, busy=0 for exactly one cycle, then IDLE.
// - Handshake: transfer occurs when cand_valid&cand_ready.
//   - While cand_valid=1 and cand_ready=0, all cand_* outputs hold stable.
//   - cand_valid never drops without a transfer, except on rst.
//   - Back-to-back transfers give one candidate per cycle; no bubbles inside a codeword.
// - Magnitude: |x| = (x<0)?-x:x.
//   - The most-negative value (-2^(BIT_WIDTH-1)) saturates to 2^(BIT_WIDTH-1)-1.
//   - Cost is the zero-extended sum; it never overflows CW.
// - cand_last=1 only on the final pattern.
//   - Option off: idx=K.
//   - Option on: idx=K+K(K-1)/2.
// - start while busy or in FIN: ignored, not queued.
// - Inputs a1k_in/v1k_in change after capture: no effect on the current codeword.
// - rst mid-sequence: at the next edge return to IDLE, outputs 0, no done pulse.
// - cand_ready held 1 with no valid: no effect.
// CONFIGURATION
// - OSD_ORDER2_EN defined: ORD2 is reachable. Total candidates = 1+K+K(K-1)/2 (11 for K=4).
// - OSD_ORDER2_EN undefined: ORD2 logic and second-index registers are omitted.
//   - ORD1 exits to FIN. Total candidates = 1+K (5 for K=4).
// TESTING (K=4, BIT_WIDTH=6)
// - Basic order-1 sweep:
//   - Stimulus: option off; start; a1k=4'b1010; v={-3,+7,-12,+1}, idx0..3; cand_ready=1 throughout.
//   - Response: 5 candidates, one per cycle.
//     - u = 1010, 1011, 1000, 1110, 0010.
//     - cost = 0, 3, 7, 12, 1.
//     - last on idx4; done pulses 1 cycle after.
// - Backpressure:
//   - Stimulus: cand_ready toggles 0,0,1 repeatedly.
//   - Response: outputs stable across stalls; the same 5-candidate sequence appears;
//     busy stays high throughout.
// - Saturation:
//   - Stimulus: v[2]=-32; option on.
//   - Response: idx3 cost=31; pair (2,3) idx10 cost=31+|v3|.
//     - cand_last on idx10; 11 candidates total.
// - Order-2 ordering:
//   - Stimulus: option on; all v=+1.
//   - Response: masks idx5..10 = 0011, 0101, 1001, 0110, 1010, 1100, each with cost=2.
// - Start while busy:
//   - Stimulus: pulse start during idx2.
//   - Response: ignored; exactly one done pulse; a new start after done restarts at idx0.
// - Reset mid-op:
//   - Stimulus: rst at idx3.
//   - Response: next cycle cand_valid=0, busy=0, done=0; next start produces a fresh idx0.

Source files
------------

// File: rtl/osd_tep_sched.sv
// OSD test-error-pattern scheduler: emits order-0, order-1 and (with OSD_ORDER2_EN) order-2
// candidate information words with their flipped-bit reliability cost, one per handshake.
module osd_tep_sched #(
  parameter int K         = 4,
  parameter int BIT_WIDTH = 6,
  parameter int IDX_W     = $clog2(K*K+1),
  parameter int CW        = BIT_WIDTH+1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [K-1:0]           a1k_in,
  input  logic [K*BIT_WIDTH-1:0] v1k_in,
  input  logic                   cand_ready,
  output logic                   cand_valid,
  output logic [K-1:0]           cand_u,
  output logic [K-1:0]           cand_mask,
  output logic [CW-1:0]          cand_cost,
  output logic [IDX_W-1:0]       cand_idx,
  output logic                   cand_last,
  output logic                   busy,
  output logic                   done
);

  localparam int IW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ORD0,
    S_ORD1,
`ifdef OSD_ORDER2_EN
    S_ORD2,
`endif
    S_FIN
  } state_t;

  state_t                 state, state_n;
  logic [K-1:0]           a_r;
  logic [K*BIT_WIDTH-1:0] v_r;
  logic [IW-1:0]          i_r, i_n;
  logic [IDX_W-1:0]       idx_r, idx_n;
`ifdef OSD_ORDER2_EN
  logic [IW-1:0]          j_r, j_n;
`endif

  logic [K-1:0]  mask;
  logic [CW-1:0] cost;
  logic          valid;
  logic          last;

  // Most-negative code has no positive twin, so it clamps to the largest positive magnitude.
  function automatic logic [CW-1:0] mag(input logic [BIT_WIDTH-1:0] x);
    logic [BIT_WIDTH-1:0] n;
    if (x[BIT_WIDTH-1] && (x[BIT_WIDTH-2:0] == '0)) begin
      return CW'({(BIT_WIDTH-1){1'b1}});
    end else if (x[BIT_WIDTH-1]) begin
      n = -x;
      return CW'(n);
    end else begin
      return CW'(x);
    end
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      a_r   <= '0;
      v_r   <= '0;
      i_r   <= '0;
      idx_r <= '0;
`ifdef OSD_ORDER2_EN
      j_r   <= '0;
`endif
    end else begin
      state <= state_n;
      i_r   <= i_n;
      idx_r <= idx_n;
`ifdef OSD_ORDER2_EN
      j_r   <= j_n;
`endif
      if (state == S_IDLE && start) begin
        a_r <= a1k_in;
        v_r <= v1k_in;
      end
    end
  end

  always_comb begin
    state_n = state;
    i_n     = i_r;
    idx_n   = idx_r;
`ifdef OSD_ORDER2_EN
    j_n     = j_r;
`endif
    valid   = 1'b0;
    mask    = '0;
    cost    = '0;
    last    = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_ORD0;
          i_n     = '0;
          idx_n   = '0;
        end
      end
      S_ORD0: begin
        valid = 1'b1;
        busy  = 1'b1;
        if (cand_ready) begin
          state_n = S_ORD1;
          i_n     = '0;
          idx_n   = idx_r + IDX_W'(1);
        end
      end
      S_ORD1: begin
        valid = 1'b1;
        busy  = 1'b1;
        mask  = K'(1) << i_r;
        cost  = mag(v_r[i_r*BIT_WIDTH +: BIT_WIDTH]);
`ifndef OSD_ORDER2_EN
        last  = (i_r == IW'(K-1));
`endif
        if (cand_ready) begin
          idx_n = idx_r + IDX_W'(1);
          if (i_r == IW'(K-1)) begin
`ifdef OSD_ORDER2_EN
            state_n = S_ORD2;
            i_n     = '0;
            j_n     = IW'(1);
`else
            state_n = S_FIN;
`endif
          end else begin
            i_n = i_r + IW'(1);
          end
        end
      end
`ifdef OSD_ORDER2_EN
      S_ORD2: begin
        valid = 1'b1;
        busy  = 1'b1;
        mask  = (K'(1) << i_r) | (K'(1) << j_r);
        cost  = mag(v_r[i_r*BIT_WIDTH +: BIT_WIDTH]) + mag(v_r[j_r*BIT_WIDTH +: BIT_WIDTH]);
        last  = (i_r == IW'(K-2)) && (j_r == IW'(K-1));
        if (cand_ready) begin
          idx_n = idx_r + IDX_W'(1);
          if (last) begin
            state_n = S_FIN;
          end else if (j_r == IW'(K-1)) begin
            i_n = i_r + IW'(1);
            j_n = i_r + IW'(2);
          end else begin
            j_n = j_r + IW'(1);
          end
        end
      end
`endif
      S_FIN: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign cand_valid = valid;
  assign cand_mask  = mask;
  assign cand_cost  = cost;
  assign cand_last  = last;
  assign cand_u     = valid ? (a_r ^ mask) : '0;
  assign cand_idx   = valid ? idx_r : '0;

endmodule

// File: tb/tb_osd_tep_sched.sv
// Directed + randomized bench for osd_tep_sched; expected candidates come from an enumeration
// of the flip patterns and a saturating magnitude model.
module tb_osd_tep_sched;
  localparam int K  = 4;
  localparam int BW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [K-1:0]  a1k_in;
  logic [K*BW-1:0] v1k_in;
  logic          cand_ready;
  logic          cand_valid;
  logic [K-1:0]  cand_u;
  logic [K-1:0]  cand_mask;
  logic [BW:0]   cand_cost;
  logic [4:0]    cand_idx;
  logic          cand_last;
  logic          busy;
  logic          done;

  int checks   = 0;
  int failures = 0;

  int e_mask[$];
  int e_cost[$];
  int e_a;

  osd_tep_sched #(.K(K), .BIT_WIDTH(BW)) dut (
    .clk(clk), .rst(rst), .start(start), .a1k_in(a1k_in), .v1k_in(v1k_in),
    .cand_ready(cand_ready), .cand_valid(cand_valid), .cand_u(cand_u),
    .cand_mask(cand_mask), .cand_cost(cand_cost), .cand_idx(cand_idx),
    .cand_last(cand_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int smag(input int x);
    if (x == -(1 << (BW-1))) return (1 << (BW-1)) - 1;
    return (x < 0) ? -x : x;
  endfunction

  // Expected candidate list: every pattern in emission order with its summed magnitude.
  task automatic build_exp(input int a, input int v[K]);
    int pats[$];
    pats.delete();
    e_mask.delete();
    e_cost.delete();
    e_a = a;
    pats.push_back(0);
    for (int i = 0; i < K; i++) pats.push_back(1 << i);
`ifdef OSD_ORDER2_EN
    for (int i = 0; i < K; i++)
      for (int j = i + 1; j < K; j++) pats.push_back((1 << i) | (1 << j));
`endif
    foreach (pats[p]) begin
      int c = 0;
      for (int b = 0; b < K; b++) if (pats[p][b]) c += smag(v[b]);
      e_mask.push_back(pats[p]);
      e_cost.push_back(c);
    end
  endtask

  task automatic issue_start(input int a, input int v[K]);
    @(negedge clk);
    start  = 1'b1;
    a1k_in = K'(a);
    for (int b = 0; b < K; b++) v1k_in[b*BW +: BW] = BW'(v[b]);
    build_exp(a, v);
  endtask

  // mode 0: ready always high, 1: ready 0,0,1 repeating, 2: random ready.
  task automatic run_cw(input int mode, input bit inj);
    int k = 0;
    int cyc = 0;
    bit injected = 1'b0;
    int n = e_mask.size();
    while (k < n && cyc < 300) begin
      @(negedge clk);
      cyc++;
      start  = 1'b0;
      a1k_in = K'($urandom);
      v1k_in = (K*BW)'($urandom);
      case (mode)
        0:       cand_ready = 1'b1;
        1:       cand_ready = (cyc % 3 == 0);
        default: cand_ready = 1'($urandom_range(0, 1));
      endcase
      if (inj && !injected && cand_idx == 5'd2) begin
        start    = 1'b1;
        injected = 1'b1;
      end
      chk("valid", cand_valid, 1);
      chk("busy", busy, 1);
      chk("done_early", done, 0);
      chk("mask", cand_mask, e_mask[k]);
      chk("u", cand_u, e_a ^ e_mask[k]);
      chk("cost", cand_cost, e_cost[k]);
      chk("idx", cand_idx, k);
      chk("last", cand_last, (k == n - 1));
      if (cand_valid && cand_ready) k++;
    end
    if (k < n) chk("timeout", k, n);
    @(negedge clk);
    start = 1'b0;
    chk("done_pulse", done, 1);
    chk("busy_fin", busy, 0);
    chk("valid_fin", cand_valid, 0);
    @(negedge clk);
    chk("done_once", done, 0);
    chk("busy_idle", busy, 0);
    chk("valid_idle", cand_valid, 0);
  endtask

  initial begin
    int v[K];
    int reached;
    rst = 1'b1; start = 1'b0; a1k_in = '0; v1k_in = '0; cand_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", cand_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_u", cand_u, 0);
    chk("rst_cost", cand_cost, 0);
    chk("rst_idx", cand_idx, 0);
    rst = 1'b0;
    cand_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_valid", cand_valid, 0);
      chk("idle_busy", busy, 0);
    end

    v = '{-3, 7, -12, 1};
    issue_start(4'b1010, v);
    run_cw(0, 1'b0);

    issue_start(4'b1010, v);
    run_cw(1, 1'b0);

    v = '{5, -9, -32, 20};
    issue_start(4'b0110, v);
    run_cw(0, 1'b0);

    v = '{1, 1, 1, 1};
    issue_start(4'b0000, v);
    run_cw(2, 1'b0);

    v = '{-31, 12, 0, -5};
    issue_start(4'b1100, v);
    run_cw(0, 1'b1);

    for (int t = 0; t < 20; t++) begin
      for (int b = 0; b < K; b++) v[b] = $urandom_range(0, 63) - 32;
      issue_start(int'($urandom_range(0, 15)), v);
      run_cw(2, 1'b0);
    end

    v = '{2, -4, 6, -8};
    issue_start(4'b0101, v);
    reached = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      start = 1'b0;
      cand_ready = 1'b1;
      if (cand_valid && cand_idx == 5'd3) begin
        reached = 1;
        break;
      end
    end
    chk("rst_reach_idx3", reached, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_valid", cand_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("postrst_done", done, 0);
      chk("postrst_valid", cand_valid, 0);
    end

    v = '{-32, 31, -1, 0};
    issue_start(4'b1001, v);
    run_cw(1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
